pipelined_ripple_adder: RTL

Parametrised, pipelined successor to the single-cycle ripple-carry adder. Splits a DATA_BIT-wide add/subtract into STAGES ripple segments, with one register rank per segment. Sustains one operation per clock with a valid/ready handshake and output back-pressure. Reports carry and mode-correct overflow for signed and unsigned operands; sits between operand-issue logic and a result consumer in the datapath.

---
 rtl/pipelined_ripple_adder_pkg.sv | 12 +
 rtl/pipelined_ripple_adder_segment.sv | 24 ++
 rtl/pipelined_ripple_adder.sv | 109 ++++++++++
 3 files changed

// File: rtl/pipelined_ripple_adder_pkg.sv
// adder_pkg: shared types and segment sizing for the pipelined ripple adder
package adder_pkg;
    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
    typedef struct packed {
        logic valid;
        logic sub;
        logic is_signed;
    } ctrl_t;
    function automatic int seg_bit(input int data_bit, input int stages);
        return (stages < 1) ? 1 : data_bit / stages;
    endfunction
endpackage

// File: rtl/pipelined_ripple_adder_segment.sv
// adder_segment: combinational SEG_BIT-wide ripple of full-adder cells
// a/b: segment operands, carry_in/carry_out: segment carries, sum: segment sum,
// msb_carry: carry into the segment MSB (signed overflow = carry_out ^ msb_carry)
module adder_segment
    import adder_pkg::*;
#(
    parameter int SEG_BIT = 16
) (
    input  logic [SEG_BIT-1:0] a,
    input  logic [SEG_BIT-1:0] b,
    input  logic               carry_in,
    output logic [SEG_BIT-1:0] sum,
    output logic               carry_out,
    output logic               msb_carry
);
    logic [SEG_BIT:0] c;
    assign c[0] = carry_in;
    for (genvar i = 0; i < SEG_BIT; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign carry_out = c[SEG_BIT];
    assign msb_carry = c[SEG_BIT-1];
endmodule

// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: STAGES-deep segmented ripple add/sub with valid/ready and carry/overflow flags
// in: clk, reset_n, enable, sub, is_signed, summand, addend, result_ready
// out: ready, result, carry_out, over_flow, valid
module pipelined_ripple_adder
    import adder_pkg::*;
#(
    parameter int DATA_BIT = 64,
    parameter int STAGES   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    output logic                ready,
    input  logic                sub,
    input  logic                is_signed,
    input  logic [DATA_BIT-1:0] summand,
    input  logic [DATA_BIT-1:0] addend,
    input  logic                result_ready,
    output logic [DATA_BIT-1:0] result,
    output logic                carry_out,
    output logic                over_flow,
    output logic                valid
);
    localparam int SEG_BIT = seg_bit(DATA_BIT, STAGES);
    localparam int LAST    = STAGES - 1;

    if (STAGES < 1 || (DATA_BIT % ((STAGES < 1) ? 1 : STAGES)) != 0) begin : g_bad_cfg
        $error("pipelined_ripple_adder: DATA_BIT must be a multiple of STAGES and STAGES >= 1");
    end

    logic [DATA_BIT-1:0] in_a [STAGES];
    logic [DATA_BIT-1:0] in_b [STAGES];
    logic [DATA_BIT-1:0] in_s [STAGES];
    logic [DATA_BIT-1:0] nx_s [STAGES];
    logic [DATA_BIT-1:0] p_a [STAGES];
    logic [DATA_BIT-1:0] p_b [STAGES];
    logic [DATA_BIT-1:0] p_s [STAGES];
    logic [SEG_BIT-1:0]  seg_sum [STAGES];
    logic                in_c [STAGES];
    logic                nx_c [STAGES];
    logic                seg_msb_c [STAGES];
    logic                p_c [STAGES];
    ctrl_t               in_ctl [STAGES];
    ctrl_t               p_ctl [STAGES];
    logic                adv;
    logic                ovf_nx;
    logic                ovf_q;

    assign adv   = !valid || result_ready;
    assign ready = adv;

    // Rank k-1 feeds segment k; the full operand words ride along (skew) and the
    // partially built sum collects finished low segments (de-skew).
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign in_a[k]   = summand;
            assign in_b[k]   = sub ? ~addend : addend;
            assign in_s[k]   = '0;
            assign in_c[k]   = sub;
            assign in_ctl[k] = {enable, sub, is_signed};
        end else begin : g_body
            assign in_a[k]   = p_a[k-1];
            assign in_b[k]   = p_b[k-1];
            assign in_s[k]   = p_s[k-1];
            assign in_c[k]   = p_c[k-1];
            assign in_ctl[k] = p_ctl[k-1];
        end
        adder_segment #(.SEG_BIT(SEG_BIT)) u_seg (
            .a         (in_a[k][k*SEG_BIT +: SEG_BIT]),
            .b         (in_b[k][k*SEG_BIT +: SEG_BIT]),
            .carry_in  (in_c[k]),
            .sum       (seg_sum[k]),
            .carry_out (nx_c[k]),
            .msb_carry (seg_msb_c[k])
        );
        assign nx_s[k] = in_s[k] | (DATA_BIT'(seg_sum[k]) << (k * SEG_BIT));
    end

    // Signed overflow via carry-into-MSB vs carry-out; unsigned sub flags a borrow.
    assign ovf_nx = in_ctl[LAST].is_signed ? (nx_c[LAST] ^ seg_msb_c[LAST])
                                           : (nx_c[LAST] ^ in_ctl[LAST].sub);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                p_a[k]   <= '0;
                p_b[k]   <= '0;
                p_s[k]   <= '0;
                p_c[k]   <= 1'b0;
                p_ctl[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                p_a[k]   <= in_a[k];
                p_b[k]   <= in_b[k];
                p_s[k]   <= nx_s[k];
                p_c[k]   <= nx_c[k];
                p_ctl[k] <= in_ctl[k];
            end
            ovf_q <= ovf_nx;
        end
    end

    assign valid     = p_ctl[LAST].valid;
    assign result    = p_s[LAST];
    assign carry_out = p_c[LAST];
    assign over_flow = ovf_q;
endmodule
